// File: rtl/load_store_unit_pkg.sv
// Shared LSU types: operation codes, FSM states, byte-enable patterns and
// small decode helpers used by the LSU and its alignment datapath.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LB  = 3'd2,
    LHU = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } load_store_func_code;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } lsu_state_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  function automatic logic is_store(input load_store_func_code op);
    return (op == SW) || (op == SH) || (op == SB);
  endfunction

  function automatic logic is_misaligned(input load_store_func_code op,
                                         input logic [1:0]          addr_lo);
    logic bad;
    bad = 1'b0;
    case (op)
      LW, SW:      bad = (addr_lo != 2'b00);
      LH, LHU, SH: bad = addr_lo[0];
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational byte-lane steering: store byte enables and lane replication,
// plus load byte/half selection with sign or zero extension.
module lsu_data_align
  import load_store_unit_pkg::*;
(
  input  load_store_func_code op_i,
  input  logic [1:0]          addr_lo_i,
  input  logic [31:0]         wdata_i,
  input  logic [31:0]         rdata_i,
  output logic [3:0]          be_o,
  output logic [31:0]         wdata_o,
  output logic [31:0]         load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    be_o        = BE_WORD;
    wdata_o     = wdata_i;
    load_data_o = rdata_i;
    case (op_i)
      LB, LBU, SB: be_o = BE_BYTE0 << addr_lo_i;
      LH, LHU, SH: be_o = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
      default:     be_o = BE_WORD;
    endcase
    case (op_i)
      SB:      wdata_o = {4{wdata_i[7:0]}};
      SH:      wdata_o = {2{wdata_i[15:0]}};
      default: wdata_o = wdata_i;
    endcase
    case (op_i)
      LB:      load_data_o = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_data_o = {24'd0, byte_sel};
      LH:      load_data_o = {{16{half_sel[15]}}, half_sel};
      LHU:     load_data_o = {16'd0, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE -> REQ -> WAIT_RESP handshake against word-addressed memory.
// Optional response watchdog enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en_lsu_ip,
  input  load_store_func_code   lsu_operator_ip,
  input  logic [ADDR_WIDTH-1:0] addr_ip,
  input  logic [31:0]           wdata_ip,
  output logic                  lsu_busy_op,
  output logic                  data_req_op,
  input  logic                  data_gnt_ip,
  output logic [ADDR_WIDTH-1:0] data_addr_op,
  output logic                  data_we_op,
  output logic [3:0]            data_be_op,
  output logic [31:0]           data_wdata_op,
  input  logic                  data_rvalid_ip,
  input  logic [31:0]           data_rdata_ip,
  output logic [31:0]           mem_data_op,
  output logic                  mem_data_valid_op,
  output logic                  store_done_op,
  output logic                  misaligned_op,
  output logic                  bus_error_op
);

  lsu_state_e            state_q, state_d;
  load_store_func_code   op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           mem_data_q, mem_data_d;
  logic                  valid_q, valid_d;
  logic                  store_done_q, store_done_d;
  logic                  misaligned_q, misaligned_d;
  logic                  timeout_hit;

  logic [3:0]  be_aligned;
  logic [31:0] wdata_aligned;
  logic [31:0] load_data;

  lsu_data_align u_align (
    .op_i        (op_q),
    .addr_lo_i   (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .rdata_i     (data_rdata_ip),
    .be_o        (be_aligned),
    .wdata_o     (wdata_aligned),
    .load_data_o (load_data)
  );

`ifdef LSU_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       bus_error_q, bus_error_d;

  assign timeout_hit = (state_q == WAIT_RESP) && !data_rvalid_ip &&
                       (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d   = tmo_cnt_q;
    bus_error_d = timeout_hit;
    if (state_q == REQ && data_gnt_ip) begin
      tmo_cnt_d = '0;
    end else if (state_q == WAIT_RESP) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q   <= '0;
      bus_error_q <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign bus_error_op = bus_error_q;
`else
  // Watchdog length only matters when the timeout build is selected.
  logic [31:0] timeout_cycles_unused;
  assign timeout_cycles_unused = 32'(TIMEOUT_CYCLES);
  assign timeout_hit  = 1'b0;
  assign bus_error_op = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_data_d   = mem_data_q;
    valid_d      = 1'b0;
    store_done_d = 1'b0;
    misaligned_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_lsu_ip) begin
          if (is_misaligned(lsu_operator_ip, addr_ip[1:0])) begin
            misaligned_d = 1'b1;
          end else begin
            state_d = REQ;
            op_d    = lsu_operator_ip;
            addr_d  = addr_ip;
            wdata_d = wdata_ip;
          end
        end
      end
      REQ: begin
        if (data_gnt_ip) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (data_rvalid_ip) begin
          state_d = IDLE;
          if (is_store(op_q)) begin
            store_done_d = 1'b1;
          end else begin
            mem_data_d = load_data;
            valid_d    = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      op_q         <= LW;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_data_q   <= '0;
      valid_q      <= 1'b0;
      store_done_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_data_q   <= mem_data_d;
      valid_q      <= valid_d;
      store_done_q <= store_done_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Bus outputs are forced to zero outside REQ so the memory sees a quiet bus.
  assign lsu_busy_op       = (state_q != IDLE);
  assign data_req_op       = (state_q == REQ);
  assign data_we_op        = data_req_op && is_store(op_q);
  assign data_be_op        = data_req_op ? be_aligned : 4'b0000;
  assign data_addr_op      = data_req_op ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign data_wdata_op     = data_req_op ? wdata_aligned : 32'd0;
  assign mem_data_op       = mem_data_q;
  assign mem_data_valid_op = valid_q;
  assign store_done_op     = store_done_q;
  assign misaligned_op     = misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; covers the timeout path
// when LSU_TIMEOUT_EN is defined (TIMEOUT_CYCLES=4), otherwise the indefinite wait.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                en_lsu_ip = 1'b0;
  load_store_func_code lsu_operator_ip = LW;
  logic [31:0]         addr_ip = '0;
  logic [31:0]         wdata_ip = '0;
  logic                lsu_busy_op;
  logic                data_req_op;
  logic                data_gnt_ip = 1'b0;
  logic [31:0]         data_addr_op;
  logic                data_we_op;
  logic [3:0]          data_be_op;
  logic [31:0]         data_wdata_op;
  logic                data_rvalid_ip = 1'b0;
  logic [31:0]         data_rdata_ip = '0;
  logic [31:0]         mem_data_op;
  logic                mem_data_valid_op;
  logic                store_done_op;
  logic                misaligned_op;
  logic                bus_error_op;

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .en_lsu_ip         (en_lsu_ip),
    .lsu_operator_ip   (lsu_operator_ip),
    .addr_ip           (addr_ip),
    .wdata_ip          (wdata_ip),
    .lsu_busy_op       (lsu_busy_op),
    .data_req_op       (data_req_op),
    .data_gnt_ip       (data_gnt_ip),
    .data_addr_op      (data_addr_op),
    .data_we_op        (data_we_op),
    .data_be_op        (data_be_op),
    .data_wdata_op     (data_wdata_op),
    .data_rvalid_ip    (data_rvalid_ip),
    .data_rdata_ip     (data_rdata_ip),
    .mem_data_op       (mem_data_op),
    .mem_data_valid_op (mem_data_valid_op),
    .store_done_op     (store_done_op),
    .misaligned_op     (misaligned_op),
    .bus_error_op      (bus_error_op)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_quiet_bus(input string tag);
    check({tag, " busy"}, 32'(lsu_busy_op), 32'd0);
    check({tag, " req"},  32'(data_req_op), 32'd0);
    check({tag, " we"},   32'(data_we_op),  32'd0);
    check({tag, " be"},   32'(data_be_op),  32'd0);
    check({tag, " addr"}, data_addr_op,     32'd0);
    check({tag, " wdat"}, data_wdata_op,    32'd0);
  endtask

  // Accept in N, request in N+1 (held gnt_wait extra cycles), rvalid one cycle after gnt.
  task automatic run_txn(input string tag, input load_store_func_code op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int gnt_wait,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_load);
    logic st;
    st = (op == SW) || (op == SH) || (op == SB);
    en_lsu_ip = 1'b1; lsu_operator_ip = op; addr_ip = addr; wdata_ip = wdata;
    tick();
    en_lsu_ip = 1'b0; addr_ip = '0; wdata_ip = '0;
    check({tag, " req"},  32'(data_req_op), 32'd1);
    check({tag, " addr"}, data_addr_op,     {addr[31:2], 2'b00});
    check({tag, " we"},   32'(data_we_op),  32'(st));
    check({tag, " be"},   32'(data_be_op),  32'(exp_be));
    check({tag, " wdat"}, data_wdata_op,    exp_wdata);
    for (int i = 0; i < gnt_wait; i++) begin
      tick();
      check({tag, " req hold"},  32'(data_req_op), 32'd1);
      check({tag, " addr hold"}, data_addr_op,     {addr[31:2], 2'b00});
    end
    data_gnt_ip = 1'b1;
    tick();
    data_gnt_ip = 1'b0;
    check({tag, " busy wait"}, 32'(lsu_busy_op), 32'd1);
    check({tag, " req off"},   32'(data_req_op), 32'd0);
    data_rvalid_ip = 1'b1; data_rdata_ip = rdata;
    tick();
    data_rvalid_ip = 1'b0; data_rdata_ip = '0;
    check({tag, " busy done"}, 32'(lsu_busy_op), 32'd0);
    check({tag, " st_done"},   32'(store_done_op), 32'(st));
    check({tag, " ld_valid"},  32'(mem_data_valid_op), 32'(!st));
    if (!st) check({tag, " ld_data"}, mem_data_op, exp_load);
    $display("txn %s op=%s addr=0x%08h result=0x%08h", tag, op.name(), addr, mem_data_op);
    tick();
    check({tag, " pulse off"}, 32'(mem_data_valid_op | store_done_op), 32'd0);
    if (!st) check({tag, " ld hold"}, mem_data_op, exp_load);
  endtask

  task automatic run_misaligned(input string tag, input load_store_func_code op,
                                input logic [31:0] addr);
    en_lsu_ip = 1'b1; lsu_operator_ip = op; addr_ip = addr;
    tick();
    en_lsu_ip = 1'b0; addr_ip = '0;
    check({tag, " misal"}, 32'(misaligned_op), 32'd1);
    check({tag, " req"},   32'(data_req_op),   32'd0);
    check({tag, " busy"},  32'(lsu_busy_op),   32'd0);
    $display("txn %s op=%s addr=0x%08h misaligned", tag, op.name(), addr);
    tick();
    check({tag, " misal off"}, 32'(misaligned_op), 32'd0);
    check({tag, " req off"},   32'(data_req_op),   32'd0);
  endtask

  initial begin
    tick(); tick();
    check_quiet_bus("rst");
    check("rst mem_data", mem_data_op, 32'd0);
    check("rst pulses", 32'({mem_data_valid_op, store_done_op, misaligned_op, bus_error_op}), 32'd0);
    reset = 1'b1;
    tick();

    run_txn("sw",  SW,  32'h100, 32'hDEADBEEF, 32'h0,         0, 4'b1111, 32'hDEADBEEF, 32'h0);
    run_txn("lb",  LB,  32'h103, 32'h0,        32'h80FF1234, 0, 4'b1000, 32'h0,        32'hFFFFFF80);
    run_txn("lbu", LBU, 32'h103, 32'h0,        32'h80FF1234, 0, 4'b1000, 32'h0,        32'h00000080);
    run_txn("lh",  LH,  32'h102, 32'h0,        32'h9ABC0000, 0, 4'b1100, 32'h0,        32'hFFFF9ABC);
    run_txn("sh",  SH,  32'h102, 32'h00005555, 32'h0,        0, 4'b1100, 32'h55555555, 32'h0);
    run_txn("lhu", LHU, 32'h100, 32'h0,        32'h9ABC8001, 0, 4'b0011, 32'h0,        32'h00008001);
    run_txn("sb",  SB,  32'h101, 32'h000000A5, 32'h0,        0, 4'b0010, 32'hA5A5A5A5, 32'h0);
    run_txn("lb1", LB,  32'h101, 32'h0,        32'h00007F00, 0, 4'b0010, 32'h0,        32'h0000007F);
    run_txn("lw",  LW,  32'h204, 32'h0,        32'h12345678, 0, 4'b1111, 32'h0,        32'h12345678);
    run_txn("lw_gnt3", LW, 32'h300, 32'h0,     32'hCAFEF00D, 3, 4'b1111, 32'h0,        32'hCAFEF00D);

    run_misaligned("mis_lw",  LW,  32'h101);
    run_misaligned("mis_sh",  SH,  32'h103);
    run_misaligned("mis_lhu", LHU, 32'h201);
    check("mis keeps mem_data", mem_data_op, 32'hCAFEF00D);

    data_rvalid_ip = 1'b1; data_rdata_ip = 32'h11111111;
    tick();
    data_rvalid_ip = 1'b0;
    check("idle rvalid ignored", 32'(mem_data_valid_op | store_done_op), 32'd0);

    // Abort from WAIT_RESP with an asynchronous reset, then offer a stale response.
    en_lsu_ip = 1'b1; lsu_operator_ip = LW; addr_ip = 32'h400;
    tick();
    en_lsu_ip = 1'b0;
    data_gnt_ip = 1'b1;
    tick();
    data_gnt_ip = 1'b0;
    check("abort busy", 32'(lsu_busy_op), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_quiet_bus("abort");
    check("abort mem_data", mem_data_op, 32'd0);
    #1 reset = 1'b1;
    data_rvalid_ip = 1'b1; data_rdata_ip = 32'h22222222;
    tick();
    data_rvalid_ip = 1'b0;
    check("late rvalid pulse", 32'(mem_data_valid_op | store_done_op), 32'd0);
    check("late rvalid busy", 32'(lsu_busy_op), 32'd0);
    $display("txn abort addr=0x00000400 reset in WAIT_RESP");

    en_lsu_ip = 1'b1; lsu_operator_ip = LW; addr_ip = 32'h500;
    tick();
    en_lsu_ip = 1'b0;
    data_gnt_ip = 1'b1;
    tick();
    data_gnt_ip = 1'b0;
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      check("tmo early err", 32'(bus_error_op), 32'd0);
      check("tmo early busy", 32'(lsu_busy_op), 32'd1);
    end
    tick();
    check("tmo bus_error", 32'(bus_error_op), 32'd1);
    check("tmo busy", 32'(lsu_busy_op), 32'd0);
    check("tmo no result", 32'(mem_data_valid_op), 32'd0);
    tick();
    check("tmo err off", 32'(bus_error_op), 32'd0);
    $display("txn timeout addr=0x00000500 bus_error");
`else
    repeat (30) tick();
    check("no-tmo busy", 32'(lsu_busy_op), 32'd1);
    check("no-tmo err", 32'(bus_error_op), 32'd0);
    $display("txn hang addr=0x00000500 still waiting");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("no-tmo recover", 32'(lsu_busy_op), 32'd0);
`endif

    run_txn("after", LH, 32'h600, 32'h0, 32'h00007FFF, 0, 4'b0011, 32'h0, 32'h00007FFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
